// File: rtl/branch_tag_allocator_pkg.sv
// Shared definitions for the branch tag allocator: default widths, the
// b_mask and dependency-matrix types, and a popcount helper.
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 8
`endif
`ifndef N
`define N 3
`endif

package branch_tag_allocator_pkg;

  localparam int B_MASK_WIDTH   = `B_MASK_WIDTH;
  localparam int DISPATCH_WIDTH = `N;

  typedef logic [B_MASK_WIDTH-1:0] B_MASK;
  typedef logic [B_MASK_WIDTH-1:0][B_MASK_WIDTH-1:0] BTA_DEP_T;

  // Counts set bits; callers zero-extend narrower vectors into the 64-bit argument.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/branch_tag_allocator_free_tag_selector.sv
// Picks the DISPATCH_W lowest-index free tags as one-hot vectors, with a
// valid bit telling whether each pick found a free tag at all.
module free_tag_selector #(
  parameter int NUM_TAGS   = 8,
  parameter int DISPATCH_W = 3
) (
  input  logic [NUM_TAGS-1:0]                 free_vec,
  output logic [DISPATCH_W-1:0][NUM_TAGS-1:0] sel_tag,
  output logic [DISPATCH_W-1:0]               sel_valid
);

  localparam logic [NUM_TAGS-1:0] ONE = NUM_TAGS'(1);

  logic [NUM_TAGS-1:0] remaining;

  // Peel off the lowest set bit repeatedly so pick j is the j-th lowest free tag.
  always_comb begin
    remaining = free_vec;
    sel_tag   = '0;
    sel_valid = '0;
    for (int j = 0; j < DISPATCH_W; j++) begin
      sel_tag[j]   = remaining & (~remaining + ONE);
      sel_valid[j] = |remaining;
      remaining    = remaining & ~sel_tag[j];
    end
  end

endmodule

// File: rtl/branch_tag_allocator.sv
// Branch tag allocator: hands out one-hot checkpoint tags to dispatching
// branches in order, builds each slot's b_mask, and frees tags on resolve
// (a mispredict also frees every younger dependent tag).
// Optional statistics outputs are enabled with the BRANCH_TAG_STATS_EN macro.
module branch_tag_allocator
  import branch_tag_allocator_pkg::*;
#(
  parameter int NUM_TAGS   = B_MASK_WIDTH,
  parameter int DISPATCH_W = DISPATCH_WIDTH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [DISPATCH_W-1:0]            alloc_req,
  output logic [DISPATCH_W-1:0]            alloc_grant,
  output logic [DISPATCH_W*NUM_TAGS-1:0]   alloc_tag,
  output logic [DISPATCH_W*NUM_TAGS-1:0]   alloc_mask,
  input  logic                             resolve_valid,
  input  logic [NUM_TAGS-1:0]              resolve_tag,
  input  logic                             resolve_mispred,
  output logic [NUM_TAGS-1:0]              b_mask,
  output logic [$clog2(NUM_TAGS+1)-1:0]    free_count,
  output logic                             alloc_stall
`ifdef BRANCH_TAG_STATS_EN
  ,
  output logic [31:0]                      stall_cycles,
  output logic [$clog2(NUM_TAGS+1)-1:0]    peak_live
`endif
);

  localparam int FCW = $clog2(NUM_TAGS + 1);

  logic [NUM_TAGS-1:0]                 live, live_n;
  logic [NUM_TAGS-1:0][NUM_TAGS-1:0]   dep, dep_n;
  logic [NUM_TAGS-1:0]                 clear, kill, older;
  logic                                squash, open, resolve_hit;
  logic [DISPATCH_W-1:0]               slot_grant;
  logic [DISPATCH_W-1:0][NUM_TAGS-1:0] slot_tag, slot_mask, sel_tag;
  logic [DISPATCH_W-1:0]               sel_valid;
  int unsigned                         used;

  free_tag_selector #(
    .NUM_TAGS   (NUM_TAGS),
    .DISPATCH_W (DISPATCH_W)
  ) u_sel (
    .free_vec  (~live),
    .sel_tag   (sel_tag),
    .sel_valid (sel_valid)
  );

  // In-order grant with prefix-OR masks; a mispredict squashes the whole group.
  always_comb begin
    clear      = resolve_valid ? resolve_tag : '0;
    squash     = resolve_valid & resolve_mispred;
    slot_grant = '0;
    slot_tag   = '0;
    slot_mask  = '0;
    older      = '0;
    used       = 0;
    open       = 1'b1;
    for (int k = 0; k < DISPATCH_W; k++) begin
      slot_mask[k] = (live & ~clear) | older;
      if (alloc_req[k] && open) begin
        open = 1'b0;
        for (int j = 0; j < DISPATCH_W; j++) begin
          if ((j == used) && sel_valid[j] && !squash && !reset) begin
            slot_grant[k] = 1'b1;
            slot_tag[k]   = sel_tag[j];
            open          = 1'b1;
          end
        end
        if (slot_grant[k]) begin
          older = older | slot_tag[k];
          used  = used + 1;
        end
      end
    end
    alloc_stall = !squash && !reset && |(alloc_req & ~slot_grant);
  end

  assign alloc_grant = slot_grant;
  assign alloc_tag   = slot_tag;
  assign alloc_mask  = reset ? '0 : slot_mask;
  assign b_mask      = live;

  // Next-state live/dep: apply the resolve first, then record newly granted tags.
  always_comb begin
    resolve_hit = resolve_valid && |(resolve_tag & live);
    kill        = resolve_tag;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (|(dep[t] & resolve_tag)) kill[t] = 1'b1;
    end
    live_n = live;
    dep_n  = dep;
    if (resolve_hit) begin
      if (resolve_mispred) begin
        live_n = live & ~kill;
        for (int t = 0; t < NUM_TAGS; t++) begin
          if (kill[t]) dep_n[t] = '0;
        end
      end else begin
        live_n = live & ~resolve_tag;
        for (int t = 0; t < NUM_TAGS; t++) begin
          dep_n[t] = dep[t] & ~resolve_tag;
        end
      end
    end
    for (int k = 0; k < DISPATCH_W; k++) begin
      if (slot_grant[k]) begin
        live_n = live_n | slot_tag[k];
        for (int t = 0; t < NUM_TAGS; t++) begin
          if (slot_tag[k][t]) dep_n[t] = slot_mask[k];
        end
      end
    end
  end

  // Live tags, dependency matrix and free count are all updated together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live       <= '0;
      dep        <= '0;
      free_count <= FCW'(NUM_TAGS);
    end else begin
      live       <= live_n;
      dep        <= dep_n;
      free_count <= FCW'(NUM_TAGS - int'(popcount(64'(live_n))));
    end
  end

`ifdef BRANCH_TAG_STATS_EN
  // Saturating stall counter and high-water mark of live tags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      peak_live    <= '0;
    end else begin
      if (alloc_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (popcount(64'(live_n)) > 32'(peak_live)) begin
        peak_live <= FCW'(popcount(64'(live_n)));
      end
    end
  end
`endif

  // Resolving a tag that is not live means complete and dispatch disagree.
  resolve_of_live_tag: assert property (@(posedge clock) disable iff (reset)
    resolve_valid |-> |(resolve_tag & live));

endmodule
